// File: rtl/eth_pcs_pkg.sv
// rtl/eth_pcs_pkg.sv - shared PCS constants: scrambler polynomial, seed and sync header codes.
package eth_pcs_pkg;

    localparam int SCR_LEN   = 58;
    localparam int SCR_TAP_A = 38;
    localparam int SCR_TAP_B = 57;

    typedef logic [SCR_LEN-1:0] scr_state_t;

    localparam scr_state_t SCR_SEED_DEFAULT = '1;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    // 00 and 11 are never legal sync headers
    function automatic logic hdr_is_bad(input logic [1:0] hdr);
        return (hdr != HDR_DATA) && (hdr != HDR_CTRL);
    endfunction

endpackage

// File: rtl/eth_scr_step.sv
// rtl/eth_scr_step.sv - combinational DATA_WIDTH-bit advance of the x^58 + x^39 + 1 (de)scrambler.
module eth_scr_step
    import eth_pcs_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [SCR_LEN-1:0]    state,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  mode,
    input  logic                  bypass,
    output logic [SCR_LEN-1:0]    next_state,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [SCR_LEN-1:0]    s;
    logic [DATA_WIDTH-1:0] d;
    logic                  out_bit;
    logic                  fb;

    // Bits are processed MSB first; a bypassed scrambler keeps its state frozen.
    always_comb begin
        s       = state;
        d       = '0;
        out_bit = 1'b0;
        fb      = 1'b0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            out_bit = data[i] ^ s[SCR_TAP_A] ^ s[SCR_TAP_B];
            d[i]    = bypass ? data[i] : out_bit;
            fb      = mode ? out_bit : data[i];
            if (!(bypass && mode)) begin
                s = {s[SCR_LEN-2:0], fb};
            end
        end
        next_state = s;
        out_data   = d;
    end

endmodule

// File: rtl/eth_scrambler_gen.sv
// rtl/eth_scrambler_gen.sv - one-stage (de)scrambler with handshake; ETH_SCRAMBLER_HDR_ERR_CNT_EN enables header error counting.
module eth_scrambler_gen
    import eth_pcs_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SCRAMBLE   = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [1:0]            i_header,
    input  logic                  i_headervalid,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_header,
    output logic                  o_headervalid,
    input  logic                  i_ready,
    input  logic                  i_bypass,
    input  logic                  i_seed_load,
    input  logic [SCR_LEN-1:0]    i_seed,
    output logic [15:0]           o_hdr_err_cnt
);

    localparam logic SCR_MODE = (SCRAMBLE != 0);

    logic [SCR_LEN-1:0]    scr_state;
    logic [SCR_LEN-1:0]    step_state;
    logic [DATA_WIDTH-1:0] step_data;
    logic                  accept;

    assign o_ready = !o_valid || i_ready;
    assign accept  = i_valid && o_ready;

    eth_scr_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .state      (scr_state),
        .data       (i_data),
        .mode       (SCR_MODE),
        .bypass     (i_bypass),
        .next_state (step_state),
        .out_data   (step_data)
    );

    // Seed load overrides the advance of a beat accepted in the same cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            scr_state     <= SCR_SEED_DEFAULT;
            o_valid       <= 1'b0;
            o_data        <= '0;
            o_header      <= '0;
            o_headervalid <= 1'b0;
        end else begin
            if (i_seed_load) begin
                scr_state <= i_seed;
            end else if (accept) begin
                scr_state <= step_state;
            end

            if (accept) begin
                o_valid       <= 1'b1;
                o_data        <= step_data;
                o_headervalid <= i_headervalid;
                if (i_headervalid) begin
                    o_header <= i_header;
                end
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

`ifdef ETH_SCRAMBLER_HDR_ERR_CNT_EN
    logic [15:0] hdr_err_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hdr_err_cnt <= '0;
        end else if (accept && i_headervalid && hdr_is_bad(i_header)
                     && (hdr_err_cnt != 16'hFFFF)) begin
            hdr_err_cnt <= hdr_err_cnt + 16'd1;
        end
    end

    assign o_hdr_err_cnt = hdr_err_cnt;
`else
    assign o_hdr_err_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_scrambler_gen.sv
// tb/tb_eth_scrambler_gen.sv - bench: scrambler and descrambler checked against a bit-stream model.
module tb_eth_scrambler_gen;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  h;
        logic        hv;
    } exp_t;

`ifdef ETH_SCRAMBLER_HDR_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic chain = 1'b0;

    logic        vin [2];
    logic        hv_in [2];
    logic        byp [2];
    logic        sl [2];
    logic        rdy [2];
    logic [15:0] din [2];
    logic [1:0]  hin [2];
    logic [57:0] seed [2];

    logic        s_o_valid, s_o_ready, s_o_hv, s_ready_in;
    logic [15:0] s_o_data, s_o_cnt;
    logic [1:0]  s_o_hdr;
    logic        d_o_valid, d_o_ready, d_o_hv;
    logic        d_valid, d_hv;
    logic [15:0] d_data, d_o_data, d_o_cnt;
    logic [1:0]  d_hdr, d_o_hdr;

    assign s_ready_in = chain ? d_o_ready : rdy[0];
    assign d_valid    = chain ? s_o_valid : vin[1];
    assign d_data     = chain ? s_o_data  : din[1];
    assign d_hdr      = chain ? s_o_hdr   : hin[1];
    assign d_hv       = chain ? s_o_hv    : hv_in[1];

    eth_scrambler_gen #(.DATA_WIDTH(16), .SCRAMBLE(1)) u_scr (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin[0]), .o_ready(s_o_ready),
        .i_data(din[0]), .i_header(hin[0]), .i_headervalid(hv_in[0]),
        .o_valid(s_o_valid), .o_data(s_o_data), .o_header(s_o_hdr), .o_headervalid(s_o_hv),
        .i_ready(s_ready_in), .i_bypass(byp[0]), .i_seed_load(sl[0]), .i_seed(seed[0]),
        .o_hdr_err_cnt(s_o_cnt)
    );

    eth_scrambler_gen #(.DATA_WIDTH(16), .SCRAMBLE(0)) u_dsc (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(d_valid), .o_ready(d_o_ready),
        .i_data(d_data), .i_header(d_hdr), .i_headervalid(d_hv),
        .o_valid(d_o_valid), .o_data(d_o_data), .o_header(d_o_hdr), .o_headervalid(d_o_hv),
        .i_ready(rdy[1]), .i_bypass(byp[1]), .i_seed_load(sl[1]), .i_seed(seed[1]),
        .o_hdr_err_cnt(d_o_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Line stream history, oldest bit first: element 0 is bit n-58, element 19 is bit n-39.
    bit          hist [2][$];
    exp_t        sb [2][$];
    exp_t        orig_q [$];
    logic [15:0] seen [2][$];
    logic [1:0]  last_hdr [2];
    int          exp_cnt [2];
    bit          init = 1'b0;
    int          chain_acc = 0;
    int          e2e_cnt = 0;

    task automatic load_hist(input int k, input logic [57:0] s);
        hist[k].delete();
        for (int j = 0; j < 58; j++) hist[k].push_back(s[57-j]);
    endtask

    function automatic logic [15:0] model_beat(input int k, input logic [15:0] d, input logic bp);
        logic [15:0] r;
        logic        o;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            o    = d[i] ^ hist[k][19] ^ hist[k][0];
            r[i] = bp ? d[i] : o;
            if (!(bp && k == 0)) begin
                hist[k].push_back((k == 0) ? o : d[i]);
                void'(hist[k].pop_front());
            end
        end
        return r;
    endfunction

    logic        cv [2], chv [2], cr [2], qv [2], qr [2], qhv [2];
    logic [15:0] cd [2], qd [2], qc [2];
    logic [1:0]  ch [2], qh [2];

    always @(negedge clk) begin
        cv[0] = vin[0];  cd[0] = din[0];  ch[0] = hin[0];  chv[0] = hv_in[0]; cr[0] = s_ready_in;
        cv[1] = d_valid; cd[1] = d_data;  ch[1] = d_hdr;   chv[1] = d_hv;     cr[1] = rdy[1];
        qv[0] = s_o_valid; qr[0] = s_o_ready; qd[0] = s_o_data; qh[0] = s_o_hdr; qhv[0] = s_o_hv; qc[0] = s_o_cnt;
        qv[1] = d_o_valid; qr[1] = d_o_ready; qd[1] = d_o_data; qh[1] = d_o_hdr; qhv[1] = d_o_hv; qc[1] = d_o_cnt;

        if (init) begin
            for (int k = 0; k < 2; k++) begin
                logic ev;
                ev = (sb[k].size() != 0);
                chk("o_valid", k, qv[k], ev);
                chk("o_ready", k, qr[k], !ev || cr[k]);
                if (ev) begin
                    chk("o_data", k, qd[k], sb[k][0].d);
                    chk("o_header", k, qh[k], sb[k][0].h);
                    chk("o_headervalid", k, qhv[k], sb[k][0].hv);
                end
                chk("o_hdr_err_cnt", k, qc[k], CNT_EN ? exp_cnt[k] : 0);
                if (rst_n && qv[k] && cr[k]) seen[k].push_back(qd[k]);
            end
            if (rst_n && chain && qv[1] && cr[1]) begin
                if (orig_q.size() == 0) begin
                    chk("e2e_underflow", 1, 1, 0);
                end else begin
                    chk("e2e_data", 1, qd[1], orig_q[0].d);
                    chk("e2e_header", 1, qh[1], orig_q[0].h);
                    void'(orig_q.pop_front());
                    e2e_cnt++;
                end
            end
        end

        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                sb[k].delete();
                load_hist(k, '1);
                last_hdr[k] = 2'b00;
                exp_cnt[k] = 0;
                if (k == 1) begin
                    init = 1'b1;
                    orig_q.delete();
                end
            end else begin
                logic acc;
                acc = cv[k] && ((sb[k].size() == 0) || cr[k]);
                if (sb[k].size() != 0 && cr[k]) void'(sb[k].pop_front());
                if (acc) begin
                    exp_t e;
                    e.d = model_beat(k, cd[k], byp[k]);
                    if (chv[k]) last_hdr[k] = ch[k];
                    e.h = last_hdr[k];
                    e.hv = chv[k];
                    sb[k].push_back(e);
                    if (chv[k] && (ch[k] == 2'b00 || ch[k] == 2'b11) && exp_cnt[k] < 16'hFFFF)
                        exp_cnt[k]++;
                    if (chain && k == 0) begin
                        exp_t o;
                        o.d = cd[0];
                        o.h = ch[0];
                        o.hv = 1'b1;
                        orig_q.push_back(o);
                        chain_acc++;
                    end
                end
                if (sl[k]) load_hist(k, seed[k]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            vin[k] = 1'b0; hv_in[k] = 1'b0; byp[k] = 1'b0; sl[k] = 1'b0; rdy[k] = 1'b1;
            din[k] = '0; hin[k] = '0; seed[k] = '0;
        end
    endtask

    task automatic zero_beats_check(input string nm);
        seen[0].delete();
        vin[0] = 1'b1; din[0] = 16'h0000; rdy[0] = 1'b1;
        repeat (3) tick();
        vin[0] = 1'b0;
        repeat (3) tick();
        chk({nm, "_count"}, 0, seen[0].size(), 3);
        if (seen[0].size() >= 3) begin
            chk({nm, "_beat0"}, 0, seen[0][0], 16'h0000);
            chk({nm, "_beat1"}, 0, seen[0][1], 16'h0000);
            chk({nm, "_beat2"}, 0, seen[0][2], 16'h01FF);
        end
    endtask

    task automatic rand_cycle();
        logic [63:0] r64;
        for (int k = 0; k < 2; k++) begin
            r64 = {$urandom, $urandom};
            vin[k]   = ($urandom % 3) != 0;
            din[k]   = 16'($urandom);
            hin[k]   = 2'($urandom);
            hv_in[k] = 1'($urandom);
            byp[k]   = ($urandom % 8) == 0;
            sl[k]    = ($urandom % 32) == 0;
            seed[k]  = r64[57:0];
            rdy[k]   = ($urandom % 4) != 0;
        end
    endtask

    initial begin
        int cyc;
        idle_all();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        chk("reset_o_valid", 0, s_o_valid, 0);
        chk("reset_o_data", 0, s_o_data, 0);
        chk("reset_o_header", 0, s_o_hdr, 0);
        chk("reset_o_headervalid", 0, s_o_hv, 0);
        chk("reset_o_ready", 0, s_o_ready, 1);
        chk("reset_o_hdr_err_cnt", 0, s_o_cnt, 0);

        zero_beats_check("scr_seed_seq");

        rdy[0] = 1'b0; vin[0] = 1'b1; din[0] = 16'hBEEF;
        tick();
        din[0] = 16'h1357;
        for (int i = 0; i < 3; i++) begin
            chk("stall_o_ready", 0, s_o_ready, 0);
            chk("stall_o_valid", 0, s_o_valid, 1);
            tick();
        end
        rdy[0] = 1'b1;
        tick();
        din[0] = 16'h2468;
        tick();
        vin[0] = 1'b0;
        repeat (2) tick();

        seen[1].delete();
        vin[1] = 1'b1; din[1] = 16'h1234; sl[1] = 1'b1; seed[1] = '0;
        tick();
        sl[1] = 1'b0; din[1] = 16'hA5A5;
        tick();
        din[1] = 16'h0F0F;
        tick();
        vin[1] = 1'b0;
        repeat (2) tick();
        chk("seed0_count", 1, seen[1].size(), 3);
        if (seen[1].size() >= 3) begin
            chk("seed0_old_state_beat", 1, seen[1][0], 16'h1234);
            chk("seed0_A5A5", 1, seen[1][1], 16'hA5A5);
            chk("seed0_after", 1, seen[1][2], 16'h0F0F);
        end

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vin[0] = 1'b1; hv_in[0] = 1'b1;
        hin[0] = 2'b01; tick();
        hin[0] = 2'b00; tick();
        hin[0] = 2'b11; tick();
        hin[0] = 2'b10; tick();
        vin[0] = 1'b0; hv_in[0] = 1'b0;
        tick();
        chk("hdr_err_cnt_4", 0, s_o_cnt, CNT_EN ? 2 : 0);
        chk("hdr_last_good", 0, s_o_hdr, 2'b10);

        for (int i = 0; i < 600; i++) begin
            rand_cycle();
            tick();
        end
        idle_all();
        repeat (3) tick();

        rdy[0] = 1'b0; vin[0] = 1'b1; din[0] = 16'hCAFE;
        repeat (2) tick();
        chk("midrst_held_valid", 0, s_o_valid, 1);
        rst_n = 1'b0; vin[0] = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_o_valid", 0, s_o_valid, 0);
        chk("midrst_o_data", 0, s_o_data, 0);
        chk("midrst_o_header", 0, s_o_hdr, 0);
        chk("midrst_o_headervalid", 0, s_o_hv, 0);
        chk("midrst_o_ready", 0, s_o_ready, 1);
        zero_beats_check("postrst_seq");

        rst_n = 1'b0; chain = 1'b1;
        idle_all();
        repeat (2) tick();
        rst_n = 1'b1;
        cyc = 0;
        while (chain_acc < 1000 && cyc < 8000) begin
            vin[0]   = ($urandom % 4) != 0;
            din[0]   = 16'($urandom);
            hin[0]   = ($urandom % 2) != 0 ? 2'b01 : 2'b10;
            hv_in[0] = 1'b1;
            rdy[1]   = ($urandom % 3) != 0;
            tick();
            cyc++;
        end
        vin[0] = 1'b0; rdy[1] = 1'b1;
        repeat (6) tick();
        chk("chain_beats_sent", 0, (chain_acc >= 1000) ? 1 : 0, 1);
        chk("chain_beats_recovered", 1, e2e_cnt, chain_acc);
        rst_n = 1'b0; chain = 1'b0;
        idle_all();
        repeat (2) tick();
        rst_n = 1'b1;

`ifdef ETH_SCRAMBLER_HDR_ERR_CNT_EN
        vin[0] = 1'b1; hv_in[0] = 1'b1; hin[0] = 2'b00;
        repeat (70000) tick();
        vin[0] = 1'b0;
        tick();
        chk("hdr_err_cnt_sat", 0, s_o_cnt, 16'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
